spi_slave_core: RTL and testbench

Byte-oriented SPI target (slave) used by the diagnostics controller to exchange command and data bytes with an external SPI master. Everything runs on the single system clock i_Clk. The SPI pins are oversampled through synchronizers in the i_Clk domain. Received bytes are delivered as a one-cycle valid pulse. Reply bytes are queued with a one-cycle load strobe and shifted out on the next byte transfer.

---
 rtl/spi_slave_core.sv | 131 +++++++++++++
 tb/tb_spi_slave_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// Byte-oriented SPI target with oversampled SCK/CS_n/MOSI in the i_Clk domain.
// Received bytes pulse o_RX_DV; reply bytes are queued via i_TX_DV.
module spi_slave_core #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_SPI_Clk,
    output logic       o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    localparam logic [1:0] MODE = 2'(SPI_MODE);
    localparam logic CPOL = MODE[1];
    localparam logic CPHA = MODE[0];
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    logic [2:0] sck_pipe_q, sck_pipe_d;
    logic [2:0] cs_pipe_q, cs_pipe_d;
    logic [1:0] mosi_pipe_q, mosi_pipe_d;
    logic [1:0] warm_q, warm_d;
    logic       armed_q, armed_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic       miso_q, miso_d;

    logic sck_sync, sck_dly, cs_sync, cs_dly, mosi_sync;
    logic sck_rise, sck_fall, active, cs_fall;
    logic sample_edge, shift_edge;

    assign sck_sync  = sck_pipe_q[1];
    assign sck_dly   = sck_pipe_q[2];
    assign cs_sync   = cs_pipe_q[1];
    assign cs_dly    = cs_pipe_q[2];
    assign mosi_sync = mosi_pipe_q[1];

    assign sck_rise = sck_sync & ~sck_dly;
    assign sck_fall = ~sck_sync & sck_dly;

    // After reset, CS_n must be seen high before a selection counts.
    assign active  = armed_q & ~cs_sync;
    assign cs_fall = active & cs_dly;

    assign sample_edge = active & (SAMPLE_RISE ? sck_rise : sck_fall);
    assign shift_edge  = active & (SAMPLE_RISE ? sck_fall : sck_rise);

    always_comb begin
        sck_pipe_d  = {sck_pipe_q[1:0], i_SPI_Clk};
        cs_pipe_d   = {cs_pipe_q[1:0], i_SPI_CS_n};
        mosi_pipe_d = {mosi_pipe_q[0], i_SPI_MOSI};
        warm_d      = warm_q[1] ? warm_q : {warm_q[0], 1'b1};
        armed_d     = armed_q | (warm_q[1] & cs_sync);
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        tx_buf_d    = tx_buf_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;

        if (i_TX_DV) begin
            tx_buf_d = i_TX_Byte;
        end

        if (!active) begin
            cnt_d      = 3'd0;
            rx_shift_d = 7'd0;
        end else begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[5:0], mosi_sync};
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    rx_byte_d = {rx_shift_q, mosi_sync};
                    rx_dv_d   = 1'b1;
                end
            end
            // Byte start: selection, or the first shift edge of a byte.
            if (cs_fall || (shift_edge && cnt_q == 3'd0)) begin
                tx_shift_d = tx_buf_q[6:0];
                miso_d     = tx_buf_q[7];
            end else if (shift_edge) begin
                tx_shift_d = {tx_shift_q[5:0], 1'b0};
                miso_d     = tx_shift_q[6];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sck_pipe_q  <= {3{CPOL}};
            cs_pipe_q   <= 3'b111;
            mosi_pipe_q <= 2'b00;
            warm_q      <= 2'b00;
            armed_q     <= 1'b0;
            cnt_q       <= 3'd0;
            rx_shift_q  <= 7'd0;
            rx_byte_q   <= 8'd0;
            rx_dv_q     <= 1'b0;
            tx_buf_q    <= 8'd0;
            tx_shift_q  <= 7'd0;
            miso_q      <= 1'b0;
        end else begin
            sck_pipe_q  <= sck_pipe_d;
            cs_pipe_q   <= cs_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            tx_buf_q    <= tx_buf_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
        end
    end

    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_MISO = cs_sync ? 1'bz : miso_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench for spi_slave_core: one instance per SPI mode,
// a bit-banged master per call, RX and MISO results checked from queues.
module tb_spi_slave_core;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] sck, cs_n, tx_dv, rx_dv, miso;
    logic       mosi;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];

    int total = 0;
    int bad = 0;
    logic [7:0] reply_val;
    bit         reply_arm;
    logic [7:0] tx_q [$];
    rx_exp_t    rx_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wire so;
        spi_slave_core #(.SPI_MODE(g)) u_dut (
            .i_Clk     (clk),
            .i_Rst_L   (rst_l),
            .o_RX_DV   (rx_dv[g]),
            .o_RX_Byte (rx_byte[g]),
            .i_TX_DV   (tx_dv[g]),
            .i_TX_Byte (tx_byte[g]),
            .i_SPI_Clk (sck[g]),
            .o_SPI_MISO(so),
            .i_SPI_MOSI(mosi),
            .i_SPI_CS_n(cs_n[g])
        );
        assign miso[g] = so;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-cycle master housekeeping: strobe release, reply, latency probe.
    task automatic hook(input int m, input int idx, input bit lat);
        if (tx_dv[m]) tx_dv[m] = 1'b0;
        if (reply_arm && rx_dv[m]) begin
            tx_byte[m] = reply_val;
            tx_dv[m]   = 1'b1;
            reply_arm  = 1'b0;
        end
        if (lat && idx == 2) chk("rx_dv_early", {7'd0, rx_dv[m]}, 8'd0);
        if (lat && idx == 3) chk("rx_dv_lat", {7'd0, rx_dv[m]}, 8'd1);
    endtask

    task automatic idle(input int m, input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            hook(m, 0, 1'b0);
        end
    endtask

    task automatic half(input int m, input bit lat);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            hook(m, i, lat);
        end
    endtask

    task automatic load(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        idle(m, 2);
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        idle(m, 8);
    endtask

    task automatic cs_high(input int m);
        idle(m, 8);
        cs_n[m] = 1'b1;
        idle(m, 8);
    endtask

    task automatic xfer(input int m, input logic [7:0] b, input int nbits,
                        input bit full, input logic [7:0] exp_miso);
        logic [7:0] got;
        logic       cpha;
        got  = 8'd0;
        cpha = m[0];
        if (full) begin
            rx_q.push_back('{mode: 2'(m), data: b});
            tx_q.push_back(exp_miso);
        end
        for (int i = 7; i > 7 - nbits; i--) begin
            bit lat;
            lat = full && (i == 0);
            if (!cpha) begin
                mosi = b[i];
                half(m, 1'b0);
                got = {got[6:0], miso[m]};
                sck[m] = ~sck[m];
                half(m, lat);
                sck[m] = ~sck[m];
            end else begin
                sck[m] = ~sck[m];
                mosi = b[i];
                half(m, 1'b0);
                got = {got[6:0], miso[m]};
                sck[m] = ~sck[m];
                half(m, lat);
            end
        end
        if (full) chk("miso", got, tx_q.pop_front());
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m]) begin
                if (rx_q.size() == 0) begin
                    chk("rx_extra", {7'd0, rx_dv[m]}, 8'd0);
                end else begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    chk("rx_mode", 8'(m), {6'd0, e.mode});
                    chk("rx_byte", rx_byte[m], e.data);
                end
            end
        end
    end

    initial begin
        rst_l     = 1'b0;
        mosi      = 1'b0;
        reply_arm = 1'b0;
        reply_val = 8'd0;
        cs_n      = 4'hF;
        tx_dv     = 4'h0;
        for (int m = 0; m < 4; m++) begin
            sck[m]     = m[1];
            tx_byte[m] = 8'd0;
        end
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk("rst_rx_dv", {7'd0, rx_dv[m]}, 8'd0);
            chk("rst_rx_byte", rx_byte[m], 8'd0);
        end
        idle(0, 4);

        // First byte after reset returns the cleared buffer.
        cs_low(0);
        xfer(0, 8'hAA, 8, 1'b1, 8'h00);
        cs_high(0);

        // Reply path, back-to-back with CS_n held low.
        load(0, 8'h5A);
        cs_low(0);
        reply_val = 8'h03;
        reply_arm = 1'b1;
        xfer(0, 8'h77, 8, 1'b1, 8'h5A);
        xfer(0, 8'h00, 8, 1'b1, 8'h03);
        cs_high(0);
        chk("reply_used", {7'd0, reply_arm}, 8'd0);

        // Buffer resent unchanged.
        cs_low(0);
        xfer(0, 8'h66, 8, 1'b1, 8'h03);
        xfer(0, 8'h99, 8, 1'b1, 8'h03);
        xfer(0, 8'h55, 8, 1'b1, 8'h03);
        cs_high(0);

        // Deselect mid-byte discards the partial byte.
        cs_low(0);
        xfer(0, 8'hF0, 4, 1'b0, 8'h00);
        cs_high(0);
        cs_low(0);
        xfer(0, 8'h88, 8, 1'b1, 8'h03);
        cs_high(0);

        for (int m = 1; m < 4; m++) begin
            load(m, 8'h5A);
            cs_low(m);
            xfer(m, 8'hAA, 8, 1'b1, 8'h5A);
            cs_high(m);
        end

        // Reset mid-transfer: ignored until CS_n toggles.
        cs_low(0);
        xfer(0, 8'hC3, 4, 1'b0, 8'h00);
        @(negedge clk);
        rst_l = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        chk("rst2_rx_byte", rx_byte[0], 8'd0);
        idle(0, 4);
        xfer(0, 8'hE7, 8, 1'b0, 8'h00);
        chk("unarmed_rx_byte", rx_byte[0], 8'd0);
        cs_high(0);
        cs_low(0);
        xfer(0, 8'h3C, 8, 1'b1, 8'h00);
        cs_high(0);

        idle(0, 10);
        chk("rx_pending", 8'(rx_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
